// File: rtl/vending_pkg.sv
// ============================================================================
// Module  : vending_pkg
// Brief   : Coin encodings, cent values and dispenser state shared with the vendor FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vending_pkg;

  localparam int CENTS_W = 8;

  localparam logic [2:0] QUARTER = 3'd4;
  localparam logic [2:0] DIME    = 3'd2;
  localparam logic [2:0] NICKEL  = 3'd1;

  localparam logic [CENTS_W-1:0] QUARTER_CENTS = 8'd25;
  localparam logic [CENTS_W-1:0] DIME_CENTS    = 8'd10;
  localparam logic [CENTS_W-1:0] NICKEL_CENTS  = 8'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } disp_state_t;

  function automatic logic [CENTS_W-1:0] coin_cents(input logic [2:0] c);
    logic [CENTS_W-1:0] v;
    case (c)
      QUARTER: v = QUARTER_CENTS;
      DIME:    v = DIME_CENTS;
      NICKEL:  v = NICKEL_CENTS;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/change_dispenser_pulse_timer.sv
// ============================================================================
// Module  : pulse_timer
// Brief   : Loadable down-counter; tc is high while the count sits at zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign tc = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// Module  : change_dispenser
// Brief   : Greedy coin payout (quarter, dime, nickel), one eject pulse at a time.
//           Optional per-denomination stock tracking under COIN_INVENTORY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module change_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int MAX_CHANGE   = 35
`ifdef COIN_INVENTORY_EN
  ,
  parameter int INV_INIT     = 8
`endif
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               request,
  input  logic [CENTS_W-1:0] amount,
  output logic               ready,
  output logic [2:0]         coin,
  output logic [CENTS_W-1:0] remaining,
  output logic               done,
  output logic               error
`ifdef COIN_INVENTORY_EN
  ,
  input  logic               refill,
  output logic [2:0]         low_stock
`endif
);

  localparam int c_TIMER_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int c_TIMER_W   = (c_TIMER_MAX > 1) ? $clog2(c_TIMER_MAX) : 1;
  localparam logic [CENTS_W-1:0] c_MAX = CENTS_W'(MAX_CHANGE);

  disp_state_t        r_state;
  disp_state_t        w_state_nxt;
  disp_state_t        w_check_nxt;
  logic [2:0]         r_coin;
  logic [2:0]         w_coin_nxt;
  logic [CENTS_W-1:0] r_remaining;
  logic [CENTS_W-1:0] w_remaining_nxt;
  logic               r_ready;
  logic               r_done;
  logic               r_error;
  logic               w_ready_nxt;
  logic               w_done_nxt;
  logic               w_error_nxt;
  logic               w_tc;
  logic               w_load;
  logic [c_TIMER_W-1:0] w_load_value;
  logic               w_bad_req;
  logic [2:0]         w_avail;
  logic [2:0]         w_pick;
  logic               w_pulse_end;

  assign w_pulse_end = (r_state == ST_PULSE) && w_tc;
  assign w_bad_req   = (r_remaining > c_MAX) || ((r_remaining % 8'd5) != 8'd0);

  // Largest coin that fits the amount still owed and is in stock
  always_comb begin
    w_pick = 3'b000;
    if (w_avail[2] && (r_remaining >= QUARTER_CENTS)) begin
      w_pick = QUARTER;
    end else if (w_avail[1] && (r_remaining >= DIME_CENTS)) begin
      w_pick = DIME;
    end else if (w_avail[0] && (r_remaining >= NICKEL_CENTS)) begin
      w_pick = NICKEL;
    end
  end

  // Selection decision, used from CHECK and again on the last GAP cycle
  always_comb begin
    w_check_nxt = ST_ERROR;
    if (w_bad_req) begin
      w_check_nxt = ST_ERROR;
    end else if (r_remaining == '0) begin
      w_check_nxt = ST_DONE;
    end else if (w_pick != 3'b000) begin
      w_check_nxt = ST_PULSE;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state     <= ST_IDLE;
      r_coin      <= 3'b000;
      r_remaining <= '0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_coin      <= w_coin_nxt;
      r_remaining <= w_remaining_nxt;
      r_ready     <= w_ready_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (request) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = w_check_nxt;
      ST_PULSE: if (w_tc) w_state_nxt = ST_GAP;
      ST_GAP:   if (w_tc) w_state_nxt = w_check_nxt;
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERROR: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_coin_nxt      = 3'b000;
    w_ready_nxt     = (w_state_nxt == ST_IDLE);
    w_done_nxt      = (w_state_nxt == ST_DONE);
    w_error_nxt     = (w_state_nxt == ST_ERROR);
    w_remaining_nxt = r_remaining;
    w_load          = 1'b0;
    w_load_value    = c_TIMER_W'(GAP_CYCLES - 1);
    if (w_state_nxt == ST_PULSE) begin
      w_coin_nxt = (r_state == ST_PULSE) ? r_coin : w_pick;
    end
    if ((w_state_nxt == ST_PULSE) && (r_state != ST_PULSE)) begin
      w_load       = 1'b1;
      w_load_value = c_TIMER_W'(PULSE_CYCLES - 1);
    end else if ((w_state_nxt == ST_GAP) && (r_state != ST_GAP)) begin
      w_load       = 1'b1;
    end
    if ((r_state == ST_IDLE) && request) begin
      w_remaining_nxt = amount;
    end else if (w_pulse_end) begin
      w_remaining_nxt = r_remaining - coin_cents(r_coin);
    end
  end

  pulse_timer #(
    .WIDTH(c_TIMER_W)
  ) u_timer (
    .clock      (clock),
    .clear      (clear),
    .load       (w_load),
    .load_value (w_load_value),
    .tc         (w_tc)
  );

`ifdef COIN_INVENTORY_EN
  logic [CENTS_W-1:0] r_stock [3];
  logic [CENTS_W-1:0] w_stock_nxt [3];
  logic               r_refill_pend;
  logic               w_reload;
  logic [2:0]         r_low_stock;

  // A refill seen mid-pulse is held back so it lands after that pulse's decrement
  assign w_reload = w_pulse_end ? (refill || r_refill_pend)
                                : (refill && (r_state != ST_PULSE));

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_stock_nxt[i] = r_stock[i];
      w_avail[i]     = (r_stock[i] != '0);
    end
    if (w_reload) begin
      for (int i = 0; i < 3; i++) w_stock_nxt[i] = CENTS_W'(INV_INIT);
    end else if (w_pulse_end) begin
      for (int i = 0; i < 3; i++) begin
        if (r_coin[i]) w_stock_nxt[i] = r_stock[i] - CENTS_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < 3; i++) begin
        r_stock[i]     <= CENTS_W'(INV_INIT);
        r_low_stock[i] <= (INV_INIT == 0);
      end
      r_refill_pend <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_stock[i]     <= w_stock_nxt[i];
        r_low_stock[i] <= (w_stock_nxt[i] == '0);
      end
      if (w_pulse_end) begin
        r_refill_pend <= 1'b0;
      end else if (refill && (r_state == ST_PULSE)) begin
        r_refill_pend <= 1'b1;
      end
    end
  end

  assign low_stock = r_low_stock;
`else
  assign w_avail = 3'b111;
`endif

  assign ready     = r_ready;
  assign coin      = r_coin;
  assign remaining = r_remaining;
  assign done      = r_done;
  assign error     = r_error;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// Module  : tb_change_dispenser
// Brief   : Randomized bench for change_dispenser against a greedy payout timeline model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_change_dispenser;
  import vending_pkg::*;

  localparam int PULSE_CYCLES = 4;
  localparam int GAP_CYCLES   = 4;
  localparam int MAX_CHANGE   = 40;
`ifdef COIN_INVENTORY_EN
  localparam int INV_INIT     = 1;
  localparam bit HAS_INV      = 1'b1;
`else
  localparam int INV_INIT     = 8;
  localparam bit HAS_INV      = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       request = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       ready;
  logic [2:0] coin;
  logic [7:0] remaining;
  logic       done;
  logic       error;
`ifdef COIN_INVENTORY_EN
  logic       refill = 1'b0;
  logic [2:0] low_stock;
`endif

  change_dispenser #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES),
    .MAX_CHANGE   (MAX_CHANGE)
`ifdef COIN_INVENTORY_EN
    ,
    .INV_INIT     (INV_INIT)
`endif
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .request   (request),
    .amount    (amount),
    .ready     (ready),
    .coin      (coin),
    .remaining (remaining),
    .done      (done),
    .error     (error)
`ifdef COIN_INVENTORY_EN
    ,
    .refill    (refill),
    .low_stock (low_stock)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] coin;
    logic       done;
    logic       error;
    logic       ready;
    logic [7:0] rem;
  } exp_t;

  exp_t q[$];
  int   stock[3];
  int   cents[3] = '{5, 10, 25};
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int c, input bit d, input bit e, input bit r, input int rem);
    exp_t x;
    x.coin = 3'(c); x.done = d; x.error = e; x.ready = r; x.rem = 8'(rem);
    q.push_back(x);
  endtask

  // Cycle-by-cycle expectation from the accepting edge onward
  task automatic build(input int a);
    int rem;
    int pick;
    bit stuck;
    rem = a;
    stuck = 1'b0;
    q.delete();
    push(0, 0, 0, 0, rem);
    if (a > MAX_CHANGE || (a % 5) != 0) begin
      push(0, 0, 1, 0, rem);
    end else begin
      while (rem > 0 && !stuck) begin
        pick = -1;
        for (int k = 2; k >= 0; k--)
          if (pick < 0 && cents[k] <= rem && (!HAS_INV || stock[k] > 0)) pick = k;
        if (pick < 0) begin
          stuck = 1'b1;
        end else begin
          repeat (PULSE_CYCLES) push(1 << pick, 0, 0, 0, rem);
          rem -= cents[pick];
          stock[pick]--;
          repeat (GAP_CYCLES) push(0, 0, 0, 0, rem);
        end
      end
      if (rem == 0) push(0, 1, 0, 0, rem);
      else          push(0, 0, 1, 0, rem);
    end
    push(0, 0, 0, 1, rem);
  endtask

  task automatic check_reset_outputs(input string where);
    check_value({where, ".coin"},  32'(coin), 0);
    check_value({where, ".ready"}, 32'(ready), 1);
    check_value({where, ".rem"},   32'(remaining), 0);
    check_value({where, ".done"},  32'(done), 0);
    check_value({where, ".error"}, 32'(error), 0);
  endtask

  task automatic do_refill();
`ifdef COIN_INVENTORY_EN
    refill = 1'b1;
    @(posedge clock); #1;
    refill = 1'b0;
`endif
    for (int k = 0; k < 3; k++) stock[k] = INV_INIT;
  endtask

  // Starts #1 after an edge with the DUT idle; ends the same way. abort_at=-2 picks randomly.
  task automatic run_txn(input int a, input int abort_at);
    int n;
    int ab;
    build(a);
    n  = q.size();
    ab = abort_at;
    if (ab == -2) ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1;
    request = 1'b1;
    amount  = 8'(a);
    @(posedge clock); #1;
    for (int i = 0; i < n; i++) begin
      check_value("coin",  32'(coin),      32'(q[i].coin));
      check_value("done",  32'(done),      32'(q[i].done));
      check_value("error", 32'(error),     32'(q[i].error));
      check_value("ready", 32'(ready),     32'(q[i].ready));
      check_value("rem",   32'(remaining), 32'(q[i].rem));
      if (i == ab) begin
        clear   = 1'b0;
        request = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        clear   = 1'b1;
        request = 1'b0;
        check_reset_outputs("abort");
        for (int k = 0; k < 3; k++) stock[k] = INV_INIT;
        repeat (3) begin
          @(posedge clock); #1;
          check_value("abort.idle_done", 32'(done), 0);
          check_value("abort.idle_coin", 32'(coin), 0);
          check_value("abort.idle_ready", 32'(ready), 1);
        end
        break;
      end
      if (i == n - 1) begin
`ifdef COIN_INVENTORY_EN
        check_value("low_stock", 32'(low_stock),
                    32'({stock[2] == 0, stock[1] == 0, stock[0] == 0}));
`endif
        request = 1'b0;
      end else begin
        request = 1'($urandom_range(0, 1));
        amount  = 8'($urandom);
        @(posedge clock); #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) stock[k] = INV_INIT;
    clear   = 1'b0;
    request = 1'b1;
    amount  = 8'd20;
    repeat (2) begin
      @(posedge clock); #1;
      check_reset_outputs("reset");
    end
    clear   = 1'b1;
    request = 1'b0;
    @(posedge clock); #1;
    check_reset_outputs("post_reset");
`ifdef COIN_INVENTORY_EN
    check_value("reset.low_stock", 32'(low_stock), 0);
`endif

    run_txn(40, -1);
    run_txn(0, -1);
    run_txn(17, -1);
    run_txn(MAX_CHANGE + 5, -1);
    run_txn(MAX_CHANGE + 1, -1);
    run_txn(MAX_CHANGE, -1);
    do_refill();
    run_txn(35, 10);

    do_refill();
    run_txn(20, -1);
    do_refill();
    run_txn(5, -1);

    for (int t = 0; t < 40; t++) begin
      int a;
      if ($urandom_range(0, 9) < 6) a = 5 * int'($urandom_range(0, MAX_CHANGE / 5));
      else                          a = int'($urandom_range(0, 255));
      if (HAS_INV && $urandom_range(0, 1) == 1) do_refill();
      run_txn(a, -2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
